// File: rtl/controle_varredura.sv
// Sonar sweep sequencer: settle servo, measure, optionally transmit,
// then bounce the servo position back and forth.
module controle_varredura #(
    parameter int N_POSICOES     = 8,
    parameter int POS_WIDTH      = 3,
    parameter int SETTLE_CYCLES  = 1_000_000,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ligar,
    input  logic                 silencio,
    input  logic                 fim_medida,
    input  logic                 fim_transmissao,
    output logic [POS_WIDTH-1:0] posicao,
    output logic                 mensurar,
    output logic                 transmitir,
    output logic                 fim_posicao,
    output logic                 timeout_medida,
    output logic [3:0]           db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARA       = 4'd1,
        ESPERA_SERVO  = 4'd2,
        MEDE          = 4'd3,
        ESPERA_MEDIDA = 4'd4,
        TIMEOUT       = 4'd5,
        FIM_MEDIDA    = 4'd6,
        TRANSMITE     = 4'd7,
        ESPERA_TX     = 4'd8,
        FIM_POSICAO   = 4'd9
    } estado_t;

    localparam int CNT_MAX =
        (SETTLE_CYCLES > TIMEOUT_CYCLES) ?
        SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_FIM =
        CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_FIM =
        CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_UM = CNT_W'(1);

    localparam logic [POS_WIDTH-1:0] POS_MAX =
        POS_WIDTH'(N_POSICOES - 1);
    localparam logic [POS_WIDTH-1:0] POS_UM = POS_WIDTH'(1);

    estado_t              estado;
    estado_t              proximo;
    logic [CNT_W-1:0]     contagem;
    logic                 descendo;
    logic                 desc_prox;
    logic [POS_WIDTH-1:0] pos_prox;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        unique case (estado)
            INICIAL: begin
                if (ligar) proximo = PREPARA;
            end
            PREPARA: begin
                proximo = ESPERA_SERVO;
            end
            ESPERA_SERVO: begin
                if (contagem == SETTLE_FIM)
                    proximo = MEDE;
            end
            MEDE: begin
                proximo = ESPERA_MEDIDA;
            end
            ESPERA_MEDIDA: begin
                // a completion on the expiry cycle beats the timeout
                if (fim_medida)
                    proximo = FIM_MEDIDA;
                else if (contagem == TIMEOUT_FIM)
                    proximo = TIMEOUT;
            end
            TIMEOUT: begin
                proximo = FIM_POSICAO;
            end
            FIM_MEDIDA: begin
                proximo = silencio ? FIM_POSICAO : TRANSMITE;
            end
            TRANSMITE: begin
                proximo = ESPERA_TX;
            end
            ESPERA_TX: begin
                if (fim_transmissao)
                    proximo = FIM_POSICAO;
            end
            FIM_POSICAO: begin
                proximo = ESPERA_SERVO;
            end
            default: begin
                proximo = INICIAL;
            end
        endcase
        if (!ligar) proximo = INICIAL;
    end

    // counter restarts on every state change, runs only while waiting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (proximo != estado) begin
            contagem <= '0;
        end else if (estado == ESPERA_SERVO ||
                     estado == ESPERA_MEDIDA) begin
            contagem <= contagem + CNT_UM;
        end
    end

    always_comb begin
        pos_prox  = posicao;
        desc_prox = descendo;
        if (N_POSICOES > 1) begin
            if (!descendo && posicao == POS_MAX) begin
                desc_prox = 1'b1;
                pos_prox  = posicao - POS_UM;
            end else if (descendo && posicao == '0) begin
                desc_prox = 1'b0;
                pos_prox  = posicao + POS_UM;
            end else if (descendo) begin
                pos_prox  = posicao - POS_UM;
            end else begin
                pos_prox  = posicao + POS_UM;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            posicao  <= '0;
            descendo <= 1'b0;
        end else if (estado == PREPARA) begin
            posicao  <= '0;
            descendo <= 1'b0;
        end else if (estado == FIM_POSICAO && ligar) begin
            posicao  <= pos_prox;
            descendo <= desc_prox;
        end
    end

    // pulses are registered from the next state so they line up
    // with the state they belong to
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mensurar       <= 1'b0;
            transmitir     <= 1'b0;
            fim_posicao    <= 1'b0;
            timeout_medida <= 1'b0;
        end else begin
            mensurar       <= (proximo == MEDE);
            transmitir     <= (proximo == TRANSMITE);
            fim_posicao    <= (proximo == FIM_POSICAO);
            timeout_medida <= (proximo == TIMEOUT);
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_controle_varredura.sv
// Randomized bench for controle_varredura against an event-time
// model of each sweep position.
module tb_controle_varredura;

    localparam int N = 4;
    localparam int S = 10;
    localparam int T = 100;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       silencio;
    logic       fim_medida;
    logic       fim_transmissao;
    logic [1:0] posicao;
    logic       mensurar;
    logic       transmitir;
    logic       fim_posicao;
    logic       timeout_medida;
    logic [3:0] db_estado;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int e_m = -1;
    int e_t = -1;
    int e_f = -1;
    int e_o = -1;
    int drv_fm = -1;
    int drv_ft = -1;
    int drv_sp = -1;
    int k = 0;
    int exp_pos = 0;

    controle_varredura #(
        .N_POSICOES     (N),
        .POS_WIDTH      (2),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ligar           (ligar),
        .silencio        (silencio),
        .fim_medida      (fim_medida),
        .fim_transmissao (fim_transmissao),
        .posicao         (posicao),
        .mensurar        (mensurar),
        .transmitir      (transmitir),
        .fim_posicao     (fim_posicao),
        .timeout_medida  (timeout_medida),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc %0d got %0h exp %0h",
                     tag, cyc, got, exp);
        end
    endtask

    function automatic int bounce(input int idx);
        int p;
        int r;
        if (N == 1) return 0;
        p = 2 * (N - 1);
        r = idx % p;
        return (r < N) ? r : p - r;
    endfunction

    task automatic tick();
        @(negedge clock);
        chk("pulses",
            {28'd0, mensurar, transmitir,
             fim_posicao, timeout_medida},
            {28'd0, cyc == e_m, cyc == e_t,
             cyc == e_f, cyc == e_o});
        chk("posicao", {30'd0, posicao}, exp_pos);
        if (cyc == e_m) chk("db_mede", {28'd0, db_estado}, 3);
        if (cyc == e_t) chk("db_tx", {28'd0, db_estado}, 7);
        if (cyc == e_f) chk("db_fimpos", {28'd0, db_estado}, 9);
        if (cyc == e_o) chk("db_timeout", {28'd0, db_estado}, 5);
        fim_medida      = (cyc == drv_fm);
        fim_transmissao = (cyc == drv_ft) || (cyc == drv_sp);
    endtask

    task automatic start();
        ligar = 1'b1;
        e_m   = cyc + 2 + S;
        tick();
        chk("db_prepara", {28'd0, db_estado}, 1);
        k       = 0;
        exp_pos = 0;
        tick();
        chk("db_servo", {28'd0, db_estado}, 2);
    endtask

    // d: cycles after mensurar that fim_medida is driven; d > T
    // means a timeout (d == T+1 still drives a late, ignored pulse)
    task automatic run_pos(input int d, input int e,
                           input bit s, input bit cancel);
        int c;
        int tx;
        int to;
        int fp;
        c        = e_m;
        silencio = s;
        tx       = -1;
        to       = -1;
        if (d <= T) begin
            drv_fm = c + d;
            if (s) begin
                fp = c + d + 2;
            end else begin
                tx = c + d + 2;
                fp = tx + e + 1;
            end
        end else begin
            drv_fm = (d == T + 1) ? c + d : -1;
            to     = c + T + 1;
            fp     = c + T + 2;
        end
        drv_ft = (tx < 0) ? -1 : tx + e;
        drv_sp = ($urandom_range(0, 3) == 0) ? c + 1 : -1;
        e_t    = tx;
        e_o    = to;
        e_f    = fp;
        if (cancel) begin
            e_f    = -1;
            drv_ft = tx + 6;
            while (cyc < tx + 3) tick();
            ligar = 1'b0;
            tick();
            chk("db_off", {28'd0, db_estado}, 0);
            repeat (8) begin
                tick();
                chk("db_idle", {28'd0, db_estado}, 0);
            end
            e_t    = -1;
            e_m    = -1;
            drv_fm = -1;
            drv_ft = -1;
            drv_sp = -1;
            return;
        end
        while (cyc < fp) tick();
        k++;
        exp_pos = bounce(k);
        e_m     = fp + 1 + S;
    endtask

    task automatic rand_pos();
        int r;
        int d;
        r = int'($urandom_range(0, 9));
        if (r < 6)       d = int'($urandom_range(1, T - 1));
        else if (r == 6) d = T;
        else if (r == 7) d = T + 1;
        else             d = T + 2;
        run_pos(d, int'($urandom_range(1, 30)),
                1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        int c;
        reset           = 1'b0;
        ligar           = 1'b0;
        silencio        = 1'b0;
        fim_medida      = 1'b0;
        fim_transmissao = 1'b0;
        repeat (3) tick();
        chk("db_reset", {28'd0, db_estado}, 0);
        reset = 1'b1;
        repeat (2) tick();
        chk("db_idle0", {28'd0, db_estado}, 0);

        start();
        repeat (8) run_pos(50, 20, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            run_pos(40, 20, (i >= 1 && i <= 3), 1'b0);
        run_pos(T + 2, 20, 1'b0, 1'b0);
        run_pos(T, 20, 1'b0, 1'b0);
        run_pos(T + 1, 20, 1'b0, 1'b0);
        repeat (30) rand_pos();

        for (int i = 0; i < 8 && exp_pos != 2; i++)
            rand_pos();
        chk("pos_before_cancel", exp_pos, 2);
        run_pos(30, 20, 1'b0, 1'b1);
        start();
        rand_pos();

        c      = e_m;
        drv_fm = -1;
        drv_ft = -1;
        drv_sp = -1;
        e_t    = -1;
        e_f    = -1;
        e_o    = -1;
        while (cyc < c + 5) tick();
        #2 reset = 1'b0;
        #1;
        chk("async_pulses",
            {28'd0, mensurar, transmitir,
             fim_posicao, timeout_medida}, 0);
        chk("async_db", {28'd0, db_estado}, 0);
        chk("async_pos", {30'd0, posicao}, 0);
        ligar   = 1'b0;
        e_m     = -1;
        exp_pos = 0;
        tick();
        reset  = 1'b1;
        drv_fm = cyc + 2;
        repeat (6) begin
            tick();
            chk("db_late_fm", {28'd0, db_estado}, 0);
        end
        drv_fm = -1;
        start();
        repeat (10) rand_pos();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
